// File: rtl/fetch_pkg.sv
// Shared opcode constants and state encoding for the LC3 fetch unit.
package fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IND   = 2'd1,
    FETCH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_p_next_pc.sv
// Combinational next-PC and indirect-pointer address computation for the fetch unit.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9
) (
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [3:0]        opcode_in,
  input  logic [OFF_W-1:0]  offset_in,
  input  logic [ADDR_W-1:0] jmp_target_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] next_pc_out,
  output logic [ADDR_W-1:0] ind_addr_out,
  output logic              is_ind_out
);

  logic [ADDR_W-1:0] sext_s;
  logic [ADDR_W-1:0] rel_s;
  logic              br_taken_s;

  assign sext_s       = ADDR_W'($signed(offset_in));
  assign rel_s        = pc_in + sext_s;
  assign br_taken_s   = |(br_nzp & result_nzp);
  assign ind_addr_out = rel_s;
  assign is_ind_out   = (opcode_in == OP_LDI) || (opcode_in == OP_STI);

  // Select the new PC for control-flow opcodes; everything else keeps the PC.
  always_comb begin
    next_pc_out = pc_in;
    case (opcode_in)
      OP_BR: begin
        if (br_taken_s) begin
          next_pc_out = rel_s;
        end else begin
          next_pc_out = pc_in;
        end
      end
      OP_JSR:  next_pc_out = rel_s;
      OP_JMP:  next_pc_out = jmp_target_in;
      default: next_pc_out = pc_in;
    endcase
  end

endmodule

// File: rtl/fetch_unit_p.sv
// Multi-cycle LC3 fetch unit: PC update, optional LDI/STI pointer read, then instruction read.
module fetch_unit_p
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter int          OFF_W    = 9,
  parameter int unsigned RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [3:0]        opcode_in,
  input  logic [OFF_W-1:0]  offset_in,
  input  logic [DATA_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ea_out,
  output logic              ea_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              ir_valid_q, ir_valid_d;
  logic              ea_valid_q, ea_valid_d;

  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] ind_addr_s;
  logic              is_ind_s;

  fetch_next_pc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next_pc (
    .pc_in         (pc_q),
    .opcode_in     (opcode_in),
    .offset_in     (offset_in),
    .jmp_target_in (reg_in[ADDR_W-1:0]),
    .br_nzp        (br_nzp),
    .result_nzp    (result_nzp),
    .next_pc_out   (next_pc_s),
    .ind_addr_out  (ind_addr_s),
    .is_ind_out    (is_ind_s)
  );

  // Next-state and datapath updates; addr_q only moves on state entry so it is stable while requesting.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ea_d       = ea_q;
    ir_valid_d = 1'b0;
    ea_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          pc_d = next_pc_s;
          if (is_ind_s) begin
            state_d = IND;
            addr_d  = ind_addr_s;
          end else begin
            state_d = FETCH;
            addr_d  = next_pc_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      IND: begin
        if (mem_ack) begin
          ea_d       = mem_rdata[ADDR_W-1:0];
          ea_valid_d = 1'b1;
          addr_d     = pc_q;
          state_d    = FETCH;
        end else begin
          state_d = IND;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          ir_d       = mem_rdata;
          pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_W;
      addr_q     <= '0;
      ir_q       <= '0;
      ea_q       <= '0;
      ir_valid_q <= 1'b0;
      ea_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ea_q       <= ea_d;
      ir_valid_q <= ir_valid_d;
      ea_valid_q <= ea_valid_d;
    end
  end

  assign mem_req  = (state_q == IND) || (state_q == FETCH);
  assign busy     = (state_q != IDLE);
  assign wea_out  = 1'b0;
  assign addr_out = addr_q;
  assign pc       = pc_q;
  assign ir_out   = ir_q;
  assign ir_valid = ir_valid_q;
  assign ea_out   = ea_q;
  assign ea_valid = ea_valid_q;

endmodule

// File: tb/tb_fetch_unit_p.sv
// Directed plus random stimulus for fetch_unit_p, checked against an arithmetic reference model.
module tb_fetch_unit_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [3:0]  opcode_in;
  logic [8:0]  offset_in;
  logic [15:0] reg_in;
  logic [2:0]  br_nzp;
  logic [2:0]  result_nzp;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [15:0] addr_out;
  logic        wea_out;
  logic [15:0] pc;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [15:0] ea_out;
  logic        ea_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mpc;

  fetch_unit_p dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .opcode_in   (opcode_in),
    .offset_in   (offset_in),
    .reg_in      (reg_in),
    .br_nzp      (br_nzp),
    .result_nzp  (result_nzp),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .addr_out    (addr_out),
    .wea_out     (wea_out),
    .pc          (pc),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ea_out      (ea_out),
    .ea_valid    (ea_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1234;
    if (a == 16'h3005) return 16'h4000;
    return 16'((int'(a) * 3) ^ 32'h5A5A);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait wm cycles then acknowledge, memory data taken from the address currently presented.
  task automatic mem_cycle(input string tag, input logic [15:0] exp_addr, input int wm, input bit busy_pokes);
    for (int i = 0; i < wm; i++) begin
      fetch_start = busy_pokes ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_ack     = 1'b0;
      mem_rdata   = 16'($urandom);
      step();
      check({tag, "_hold_addr"}, 32'(addr_out), 32'(exp_addr));
      check({tag, "_hold_req"}, 32'(mem_req), 32'd1);
    end
    fetch_start = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = mem_word(addr_out);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [8:0] off, input logic [15:0] rv,
                       input logic [2:0] bn, input logic [2:0] rn, input int wi, input int wf,
                       input bit busy_pokes);
    int          s;
    logic [15:0] npc;
    logic [15:0] ia;
    bit          ind;
    s   = off[8] ? int'(off) - 512 : int'(off);
    ia  = 16'(int'(mpc) + s);
    ind = (op == 4'd10) || (op == 4'd11);
    if (op == 4'd0)       npc = ((bn & rn) != 3'b000) ? ia : mpc;
    else if (op == 4'd4)  npc = ia;
    else if (op == 4'd12) npc = rv;
    else                  npc = mpc;

    opcode_in   = op;
    offset_in   = off;
    reg_in      = rv;
    br_nzp      = bn;
    result_nzp  = rn;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    opcode_in   = 4'($urandom);
    offset_in   = 9'($urandom);
    mpc         = npc;
    check("start_busy", 32'(busy), 32'd1);
    check("start_req", 32'(mem_req), 32'd1);
    check("start_pc", 32'(pc), 32'(npc));
    if (ind) begin
      check("ind_addr", 32'(addr_out), 32'(ia));
      mem_cycle("ind", ia, wi, busy_pokes);
      check("ea_valid", 32'(ea_valid), 32'd1);
      check("ea_out", 32'(ea_out), 32'(mem_word(ia)));
      check("ind_no_ir", 32'(ir_valid), 32'd0);
    end
    check("fetch_addr", 32'(addr_out), 32'(npc));
    check("fetch_req", 32'(mem_req), 32'd1);
    mem_cycle("fetch", npc, wf, busy_pokes);
    mpc = 16'(npc + 16'd1);
    check("ir_valid", 32'(ir_valid), 32'd1);
    check("ir_out", 32'(ir_out), 32'(mem_word(npc)));
    check("pc_inc", 32'(pc), 32'(mpc));
    check("done_busy", 32'(busy), 32'd0);
    check("done_req", 32'(mem_req), 32'd0);
    check("done_ea_valid", 32'(ea_valid), 32'd0);
    check("wea", 32'(wea_out), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    fetch_start = 1'b0;
    opcode_in   = 4'd0;
    offset_in   = 9'd0;
    reg_in      = 16'd0;
    br_nzp      = 3'd0;
    result_nzp  = 3'd0;
    mem_rdata   = 16'd0;
    mem_ack     = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    step();
    mpc = 16'h3000;
    check("rst_pc", 32'(pc), 32'h3000);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_wea", 32'(wea_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_ea", 32'(ea_out), 32'd0);

    // Directed test plan sequence.
    do_op(4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 0, 0, 1'b0);
    do_op(4'b0000, 9'h1FE, 16'h0000, 3'b010, 3'b010, 0, 0, 1'b0);
    check("br_taken_pc", 32'(pc), 32'h3000);
    do_op(4'b0000, 9'h1FE, 16'h0000, 3'b010, 3'b100, 0, 0, 1'b0);
    do_op(4'b0000, 9'h0FF, 16'h0000, 3'b000, 3'b111, 0, 1, 1'b0);
    do_op(4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000, 0, 0, 1'b0);
    check("jmp_wrap_pc", 32'(pc), 32'h0000);
    do_op(4'b1100, 9'h000, 16'h2FFF, 3'b000, 3'b000, 0, 0, 1'b0);
    do_op(4'b1010, 9'h005, 16'h0000, 3'b000, 3'b000, 3, 0, 1'b1);
    check("ldi_pc", 32'(pc), 32'h3001);

    // mem_ack while idle must not disturb anything.
    step();
    check("idle_ir_valid_clear", 32'(ir_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_ir_valid", 32'(ir_valid), 32'd0);
    check("idle_ack_pc", 32'(pc), 32'(mpc));

    for (int k = 0; k < 150; k++) begin
      do_op(4'($urandom), 9'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset in the middle of FETCH with a start poked while busy.
    opcode_in   = 4'b0001;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    step();
    fetch_start = 1'b1;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    fetch_start = 1'b0;
    check("mid_rst_pc", 32'(pc), 32'h3000);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(addr_out), 32'd0);
    check("mid_rst_ir", 32'(ir_out), 32'd0);
    check("mid_rst_ea", 32'(ea_out), 32'd0);
    check("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
    check("mid_rst_ea_valid", 32'(ea_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_ir_valid", 32'(ir_valid), 32'd0);
    check("late_ack_ir", 32'(ir_out), 32'd0);
    check("late_ack_pc", 32'(pc), 32'h3000);
    mpc = 16'h3000;
    do_op(4'b0100, 9'h010, 16'h0000, 3'b000, 3'b000, 0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit_p.md
Name: fetch_unit_p

Overview:
- Parametrised multi-cycle LC3 instruction-fetch unit. Successor to the fixed-width fetch block.
- Updates the PC for BR (nzp-conditional), JMP and JSR. Fetches the next instruction through a req/ack memory read port.
- New versus the previous generation: resolves the indirect pointer for LDI/STI in a first memory access and hands the effective address downstream.
- Sits between the decode/execute stage (which supplies opcode, offset, register value and condition codes) and the unified instruction/data memory.

Parameters:
- ADDR_W, 16, address and PC width.
- DATA_W, 16, memory word and instruction width; must be >= ADDR_W.
- OFF_W, 9, width of offset_in. Sign-extended to ADDR_W; must be <= ADDR_W.
- RESET_PC, 16'h3000, PC value after reset (lower ADDR_W bits used).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  start request; sampled only in IDLE.
- opcode_in  in  4  LC3 opcode of the instruction just executed.
- offset_in  in  OFF_W  PC-relative offset, two's complement.
- reg_in  in  DATA_W  base register value for JMP; low ADDR_W bits used.
- br_nzp  in  3  BR condition mask.
- result_nzp  in  3  current condition codes.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  read completion; may be asserted in the same cycle as mem_req.
- mem_req  out  1  read request; held high until mem_ack.
- addr_out  out  ADDR_W  memory address; stable while mem_req=1.
- wea_out  out  1  write enable; constant 0 (this unit only reads).
- pc  out  ADDR_W  program counter register.
- ir_out  out  DATA_W  last fetched instruction.
- ir_valid  out  1  one-cycle pulse: ir_out updated.
- ea_out  out  ADDR_W  resolved indirect pointer for LDI/STI.
- ea_valid  out  1  one-cycle pulse: ea_out updated.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, synchronous, when rst=1 at an edge:
  - state = IDLE, pc = RESET_PC.
  - addr_out, ir_out, ea_out = 0.
  - mem_req, ir_valid, ea_valid, busy, wea_out = 0.
  - Reset overrides any in-flight access. mem_req is low in the cycle after that edge, and a late mem_ack is ignored.
- Next-PC rules, applied on the edge where IDLE samples fetch_start=1. sext = sign-extend offset_in to ADDR_W; all sums wrap modulo 2^ADDR_W.
  - BR (0000): pc + sext if (br_nzp & result_nzp) != 0, else pc. br_nzp = 000 is never taken.
  - JSR (0100): pc + sext.
  - JMP (1100): reg_in[ADDR_W-1:0].
  - All other opcodes: pc unchanged.
- On the same edge the unit latches ind_addr = pc_old + sext (the pre-update pc) for LDI (1010) and STI (1011).
- Next state from that edge: IND for LDI/STI, else FETCH.
- IND state:
  - mem_req = 1, addr_out = ind_addr.
  - On the mem_ack edge: ea_out <= mem_rdata[ADDR_W-1:0], ea_valid pulses in the next cycle, state -> FETCH.
- FETCH state:
  - mem_req = 1, addr_out = pc.
  - On the mem_ack edge: ir_out <= mem_rdata, pc <= pc + 1 (0xFFFF wraps to 0x0000 at ADDR_W=16), ir_valid pulses in the next cycle, state -> IDLE.
- When not requesting, addr_out holds its last value. mem_req is registered/state-decoded and has no combinational path from mem_ack.
- Latency with zero-wait memory (ack in the first request cycle):
  - start to ir_valid = 2 cycles for non-indirect opcodes.
  - start to ir_valid = 3 cycles for LDI/STI.
  - Each wait cycle adds 1.
- Boundary cases:
  - fetch_start while busy: ignored, not queued.
  - mem_ack in IDLE: ignored.
  - fetch_start re-asserted in the cycle ir_valid pulses: accepted, because the state is IDLE.

Decomposition:
- Package fetch_pkg holds:
  - opcode constants OP_BR, OP_JSR, OP_JMP, OP_LDI, OP_STI;
  - the state encoding IDLE/IND/FETCH.
- One sub-module, fetch_next_pc: combinational sign-extend, branch evaluation and next-PC/ind_addr computation, parametrised by ADDR_W/OFF_W.

Test Plan:
- rst held 5 cycles, then released -> pc=0x3000; mem_req, ir_valid, wea_out, busy all 0; addr_out=0.
- ADD (0001) start, zero-wait memory returning 0x1234 -> addr_out=0x3000 with mem_req; 2 cycles later ir_valid=1, ir_out=0x1234, pc=0x3001.
- BR, br_nzp=010, result_nzp=010, offset=-2 (0x1FE), pc=0x3001 -> fetch at 0x2FFF. Repeat with result_nzp=100 -> fetch at 0x3001.
- JMP with reg_in=0xFFFF -> fetch at 0xFFFF, then pc=0x0000 (wrap).
- LDI, pc=0x3000, offset=5, mem[0x3005]=0x4000, 3 ack-wait cycles -> addr_out=0x3005 held until ack, ea_out=0x4000 with ea_valid pulse, then fetch at 0x3000.
- rst asserted in FETCH before ack, and fetch_start pulsed while busy -> full reset state next cycle; the second start produces no extra fetch.
